// File: rtl/prover_compute_v_seq.sv
// Sumcheck prover V-table holder: folds V once per round through an external multiply-add unit.
// Optional macro PROVER_COMPUTE_V_SEQ_PIPE_EN: issue one pair per cycle to a pipelined, in-order unit.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module prover_compute_v_seq #(
  parameter int ngates    = 8,
  parameter int ngates_in = ngates / 2,
  parameter int nlevels   = $clog2(ngates)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic                restart,
  input  logic [`F_NBITS-1:0] tau,
  input  logic [`F_NBITS-1:0] v_in [ngates],
  output logic                madd_req,
  output logic [`F_NBITS-1:0] madd_a,
  output logic [`F_NBITS-1:0] madd_b,
  output logic [`F_NBITS-1:0] madd_tau,
  input  logic                madd_ack,
  input  logic [`F_NBITS-1:0] madd_res,
  output logic [`F_NBITS-1:0] v_0 [ngates_in],
  output logic [`F_NBITS-1:0] v_1 [ngates_in],
  output logic [`F_NBITS-1:0] v_tau [ngates_in],
  output logic                ready,
  output logic                ready_pulse,
  output logic                done
);

  localparam int SW = nlevels + 1;
  localparam int IW = nlevels - 1;

  if (ngates < 4 || (ngates & (ngates - 1)) != 0) begin : g_bad_ngates
    $error("prover_compute_v_seq: ngates must be a power of 2 and at least 4");
  end
  if (ngates_in != ngates / 2) begin : g_bad_ngates_in
    $error("prover_compute_v_seq: ngates_in is derived and must not be overridden");
  end
  if (nlevels != $clog2(ngates)) begin : g_bad_nlevels
    $error("prover_compute_v_seq: nlevels is derived and must not be overridden");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t              state, state_nx;
  logic [`F_NBITS-1:0] tab [ngates];
  logic [SW-1:0]       size;
  logic [SW-1:0]       half;
  logic [IW-1:0]       idx;
  logic                en_dly;
  logic                ready_dly;
  logic                inc;
  logic                last_pair;

  assign half        = size >> 1;
  assign inc         = en & ~en_dly;
  assign last_pair   = (SW'(idx) == half - SW'(1));
  assign ready_pulse = ready & ~ready_dly;

`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
  logic [IW-1:0] ack_cnt;
  logic          last_ack;
  assign last_ack = (SW'(ack_cnt) == half - SW'(1));
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (inc && !restart && size >= SW'(2)) state_nx = ISSUE;
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
      ISSUE: if (last_pair) state_nx = WAIT;
      WAIT:  if (madd_ack && last_ack) state_nx = WB;
`else
      ISSUE: state_nx = WAIT;
      WAIT:  if (madd_ack) state_nx = last_pair ? WB : ISSUE;
`endif
      WB:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_dly    <= 1'b1;
      ready     <= 1'b1;
      ready_dly <= 1'b1;
      done      <= 1'b0;
      size      <= '0;
      idx       <= '0;
      madd_req  <= 1'b0;
      madd_a    <= '0;
      madd_b    <= '0;
      madd_tau  <= '0;
      for (int j = 0; j < ngates; j++) tab[j] <= '0;
      for (int j = 0; j < ngates_in; j++) begin
        v_0[j]   <= '0;
        v_1[j]   <= '0;
        v_tau[j] <= '0;
      end
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
      ack_cnt <= '0;
`endif
    end else begin
      en_dly    <= en;
      ready_dly <= ready;
      case (state)
        // round start: snapshot the pairs and challenge
        IDLE: begin
          if (inc && restart) begin
            for (int j = 0; j < ngates; j++) tab[j] <= v_in[j];
            size <= SW'(ngates);
            done <= 1'b0;
          end else if (inc && size >= SW'(2)) begin
            madd_tau <= tau;
            idx      <= '0;
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
            ack_cnt  <= '0;
`endif
            for (int j = 0; j < ngates_in; j++) begin
              v_0[j]   <= (SW'(j) < half) ? tab[2*j]   : '0;
              v_1[j]   <= (SW'(j) < half) ? tab[2*j+1] : '0;
              v_tau[j] <= '0;
            end
            ready <= 1'b0;
          end
        end
        // operand issue
        ISSUE: begin
          madd_req <= 1'b1;
          madd_a   <= tab[{idx, 1'b0}];
          madd_b   <= tab[{idx, 1'b1}];
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
          if (!last_pair) idx <= idx + 1'b1;
`endif
        end
        // result collection
        WAIT: begin
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
          madd_req <= 1'b0;
`else
          if (madd_ack) begin
            v_tau[idx] <= madd_res;
            madd_req   <= 1'b0;
            if (!last_pair) idx <= idx + 1'b1;
          end
`endif
        end
        // write-back of the folded table
        WB: begin
          for (int j = 0; j < ngates_in; j++) tab[j] <= (SW'(j) < half) ? v_tau[j] : '0;
          for (int j = ngates_in; j < ngates; j++) tab[j] <= '0;
          size  <= half;
          done  <= (half == SW'(1));
          ready <= 1'b1;
        end
        default: ;
      endcase
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
      // acks come back in issue order, possibly while later pairs are still being issued
      if ((state == ISSUE || state == WAIT) && madd_ack) begin
        v_tau[ack_cnt] <= madd_res;
        if (!last_ack) ack_cnt <= ack_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prover_compute_v_seq.sv
// Bench for prover_compute_v_seq: multiply-add responder with L=3, array-level fold model and directed rounds.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_prover_compute_v_seq;
  localparam int NG = 8;
  localparam int NI = 4;
  localparam int FW = `F_NBITS;
  localparam int L  = 3;
`ifdef PROVER_COMPUTE_V_SEQ_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  localparam logic [95:0] P = 96'd4294967291;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          en = 1'b0;
  logic          restart = 1'b0;
  logic [FW-1:0] tau = '0;
  logic [FW-1:0] v_in [NG];
  logic          madd_req;
  logic [FW-1:0] madd_a, madd_b, madd_tau;
  logic          madd_ack = 1'b0;
  logic [FW-1:0] madd_res = '0;
  logic [FW-1:0] v_0 [NI];
  logic [FW-1:0] v_1 [NI];
  logic [FW-1:0] v_tau [NI];
  logic          ready, ready_pulse, done;

  prover_compute_v_seq #(.ngates(NG)) dut (
    .clk(clk), .rstb(rstb), .en(en), .restart(restart), .tau(tau), .v_in(v_in),
    .madd_req(madd_req), .madd_a(madd_a), .madd_b(madd_b), .madd_tau(madd_tau),
    .madd_ack(madd_ack), .madd_res(madd_res),
    .v_0(v_0), .v_1(v_1), .v_tau(v_tau),
    .ready(ready), .ready_pulse(ready_pulse), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] madd_f(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                           input logic [FW-1:0] t);
    logic [95:0] d, r;
    d = ({64'd0, b} % P + P - {64'd0, a} % P) % P;
    r = ({64'd0, a} % P + ({64'd0, t} % P) * d) % P;
    return r[FW-1:0];
  endfunction

  // Model state: the table, its size, and the last round's presented arrays
  logic [FW-1:0] m_tab [NG];
  logic [FW-1:0] pre_tab [NG];
  logic [FW-1:0] m_v0 [NI];
  logic [FW-1:0] m_v1 [NI];
  logic [FW-1:0] m_vt [NI];
  logic [FW-1:0] cur_tau;
  int            m_size, m_half;
  bit            m_done;

  task automatic model_reset();
    for (int j = 0; j < NG; j++) begin m_tab[j] = '0; pre_tab[j] = '0; end
    for (int j = 0; j < NI; j++) begin m_v0[j] = '0; m_v1[j] = '0; m_vt[j] = '0; end
    m_size = 0; m_half = 0; m_done = 0; cur_tau = '0;
  endtask

  task automatic model_load(input logic [FW-1:0] vals [NG]);
    m_tab = vals; m_size = NG; m_done = 0;
  endtask

  int round_push = 0;
  int push_cnt = 0;

  task automatic model_round(input logic [FW-1:0] t);
    m_half = m_size / 2;
    pre_tab = m_tab;
    cur_tau = t;
    round_push = 0;
    for (int j = 0; j < NI; j++) begin
      m_v0[j] = (j < m_half) ? pre_tab[2*j] : '0;
      m_v1[j] = (j < m_half) ? pre_tab[2*j+1] : '0;
      m_vt[j] = (j < m_half) ? madd_f(pre_tab[2*j], pre_tab[2*j+1], t) : '0;
    end
    for (int j = 0; j < NG; j++) m_tab[j] = (j < m_half) ? m_vt[j] : '0;
    m_size = m_half;
    m_done = (m_half == 1);
  endtask

  // Multiply-add unit: answers each accepted request L cycles later, in order
  typedef struct { int due; logic [FW-1:0] res; } pend_t;
  pend_t pq[$];
  pend_t pe;
  bit outstanding = 0;
  always @(negedge clk) begin
    if (!rstb) begin
      pq.delete();
      outstanding = 0;
      madd_ack = 1'b0;
      madd_res = '0;
    end else begin
      if (madd_req && (PIPE || !outstanding)) begin
        if (round_push < NI) begin
          check("op_a", madd_a, pre_tab[2*round_push]);
          check("op_b", madd_b, pre_tab[2*round_push+1]);
          check("op_tau", madd_tau, cur_tau);
        end else check("op_excess_request", round_push, NI - 1);
        pe.due = cyc + L;
        pe.res = madd_f(madd_a, madd_b, madd_tau);
        pq.push_back(pe);
        outstanding = 1;
        push_cnt++;
        round_push++;
      end
      if (pq.size() > 0 && pq[0].due == cyc + 1) begin
        madd_ack = 1'b1;
        madd_res = pq[0].res;
        void'(pq.pop_front());
        outstanding = 0;
      end else begin
        madd_ack = 1'b0;
        madd_res = '0;
      end
    end
  end

  // Compare process: whenever results are declared stable they must equal the model
  bit chk_on = 0;
  bit prev_ready = 1;
  always @(negedge clk) begin
    if (!rstb) prev_ready = 1;
    else if (chk_on) begin
      if (ready) begin
        for (int j = 0; j < NI; j++) begin
          check("cmp_v0", v_0[j], m_v0[j]);
          check("cmp_v1", v_1[j], m_v1[j]);
          check("cmp_vtau", v_tau[j], m_vt[j]);
        end
        check("cmp_done", done, m_done);
        check("cmp_idle_req", madd_req, 0);
      end
      check("cmp_ready_pulse", ready_pulse, ready & ~prev_ready);
      prev_ready = ready;
    end
  end

  task automatic check_arr(input string name, input logic [FW-1:0] act [NI],
                           input logic [FW-1:0] exp [NI]);
    for (int j = 0; j < NI; j++) check(name, act[j], exp[j]);
  endtask

  task automatic do_restart(input logic [FW-1:0] vals [NG]);
    @(posedge clk); #1;
    en = 1; restart = 1; v_in = vals;
    @(posedge clk); #1;
    model_load(vals);
    en = 0; restart = 0;
    @(negedge clk);
    check("restart_ready", ready, 1);
    check("restart_no_req", madd_req, 0);
  endtask

  task automatic finish_round(input int start, input string tag);
    int lat;
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (n == 0) check({tag, "_ready_low"}, ready, 0);
      if (ready) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    lat = cyc - start;
    check({tag, "_latency"}, lat, PIPE ? (m_half + L + 1) : (m_half * (L + 1) + 1));
    check({tag, "_pulse_first"}, ready_pulse, 1);
    check({tag, "_requests"}, round_push, m_half);
    @(negedge clk);
    check({tag, "_pulse_second"}, ready_pulse, 0);
  endtask

  task automatic do_round(input logic [FW-1:0] t, input bit expect_run, input string tag,
                          output int start);
    int p0;
    p0 = push_cnt;
    @(posedge clk); #1;
    en = 1; restart = 0; tau = t;
    @(posedge clk); #1;
    start = cyc;
    if (expect_run) model_round(t);
    en = 0;
    if (expect_run) finish_round(start, tag);
    else begin
      repeat (8) @(negedge clk);
      check({tag, "_ignored_ready"}, ready, 1);
      check({tag, "_ignored_requests"}, push_cnt - p0, 0);
    end
  endtask

  task automatic wait_req(input string tag);
    bit seen;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (madd_req) seen = 1;
    end
    if (!seen) check({tag, "_req_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  logic [FW-1:0] vals_a [NG];
  logic [FW-1:0] vals_b [NG];
  logic [FW-1:0] lit [NI];
  int st;

  initial begin
    vals_a = '{1, 2, 3, 4, 5, 6, 7, 8};
    vals_b = '{5, 9, 2, 8, 100, 1, 0, 7};
    v_in = vals_a;
    model_reset();

    // Model pins
    check("model_pin_wrap", madd_f(100, 1, 3), 32'd4294967094);
    check("model_pin_plain", madd_f(5, 9, 3), 17);

    // Scenario 1: reset state
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_req", madd_req, 0);
    check("rst_pulse", ready_pulse, 0);
    check("rst_madd_a", madd_a, 0);
    check("rst_madd_tau", madd_tau, 0);
    for (int j = 0; j < NI; j++) begin
      check("rst_v0", v_0[j], 0);
      check("rst_v1", v_1[j], 0);
      check("rst_vtau", v_tau[j], 0);
    end
    @(posedge clk); #1 rstb = 1;
    chk_on = 1;

    // Scenario 2: load 1..8, fold with tau=0
    do_restart(vals_a);
    do_round(0, 1, "s2", st);
    lit = '{1, 3, 5, 7}; check_arr("s2_v0", v_0, lit);
    lit = '{2, 4, 6, 8}; check_arr("s2_v1", v_1, lit);
    lit = '{1, 3, 5, 7}; check_arr("s2_vtau", v_tau, lit);
    check("s2_requests_lit", round_push, 4);
    check("s2_done", done, 0);

    // Scenario 3: two more folds with tau=1, then a round request on a single element
    do_round(1, 1, "s3a", st);
    lit = '{3, 7, 0, 0}; check_arr("s3a_vtau", v_tau, lit);
    do_round(1, 1, "s3b", st);
    lit = '{7, 0, 0, 0}; check_arr("s3b_vtau", v_tau, lit);
    check("s3_done", done, 1);
    do_round(5, 0, "s3c", st);
    check("s3c_done_kept", done, 1);

    // Scenario 4: en edge and restart mid-round are ignored
    do_restart(vals_b);
    check("s4_done_cleared", done, 0);
    @(posedge clk); #1;
    en = 1; tau = 3;
    @(posedge clk); #1;
    st = cyc;
    model_round(3);
    en = 0;
    wait_req("s4");
    @(posedge clk); #1;
    en = 1; restart = 1; v_in = vals_a; tau = 99;
    @(posedge clk); #1;
    en = 0; restart = 0;
    finish_round(st, "s4");
    lit = '{17, 20, 32'd4294967094, 21}; check_arr("s4_vtau", v_tau, lit);
    lit = '{5, 2, 100, 0}; check_arr("s4_v0", v_0, lit);
    do_round(0, 1, "s4b", st);
    lit = '{17, 32'd4294967094, 0, 0}; check_arr("s4b_vtau", v_tau, lit);

    // Scenario 5: asynchronous reset mid-round
    do_restart(vals_a);
    @(posedge clk); #1;
    en = 1; tau = 7;
    @(posedge clk); #1;
    model_round(7);
    en = 0;
    wait_req("s5");
    check("s5_req_before", madd_req, 1);
    @(posedge clk); #2;
    rstb = 0;
    model_reset();
    #1;
    check("s5_req_async", madd_req, 0);
    check("s5_ready_async", ready, 1);
    check("s5_vtau0_async", v_tau[0], 0);
    check("s5_v0_async", v_0[1], 0);
    @(negedge clk);
    @(posedge clk); #1 rstb = 1;
    do_round(9, 0, "s5b", st);
    check("s5b_req", madd_req, 0);
    for (int j = 0; j < NI; j++) check("s5b_vtau", v_tau[j], 0);

    repeat (3) @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
